// File: rtl/mmio_led_pwm.sv
// mmio_led_pwm: memory-mapped multi-channel LED PWM controller.
//
// Register map (word addresses):
//   0       ENABLE[NUM_CH-1:0]             RW
//   1       STATUS: [PWM_BITS-1:0] counter, [16] period-wrap flag (clear on read), RO
//   2+ch    DUTY shadow[PWM_BITS-1:0]       RW, applied at the next period boundary
//
// Ports:
//   clk      single clock, all state on rising edge
//   reset    synchronous active-high reset
//   we, re   write / read strobes
//   addr     word address
//   wdata    write data (only the low bits of each field are kept)
//   rdata    registered read data, held between reads
//   rvalid   one-cycle pulse the cycle after re
//   pwm_out  registered per-channel PWM drive at pin polarity
//
// Optional feature: define LED_PWM_FADE_EN to make the active duty step by 1
// toward the shadow at each period boundary (linear fades) instead of loading
// it directly.
module mmio_led_pwm #(
  parameter int NUM_CH     = 4,
  parameter int PWM_BITS   = 8,
  parameter int DIV        = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [3:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PS_W-1:0]     presc_reg;
  logic                tick;
  logic                wrap_tick;
  logic [PWM_BITS-1:0] cnt_reg;
  logic [NUM_CH-1:0]   enable_reg;
  logic [PWM_BITS-1:0] shadow_reg [NUM_CH];
  logic [PWM_BITS-1:0] active_reg [NUM_CH];
  logic [NUM_CH-1:0]   level;
  logic [NUM_CH-1:0]   pwm_reg;
  logic                wrap_reg;
  logic [31:0]         rdata_reg;
  logic                rvalid_reg;
  logic [31:0]         read_mux;
  logic                status_rd;
  logic                unused_wdata;

  // Only the low bits of wdata are architecturally meaningful.
  assign unused_wdata = ^wdata;

  assign tick      = (presc_reg == PS_LAST);
  assign wrap_tick = tick && (cnt_reg == CNT_MAX);
  assign status_rd = re && (addr == 4'd1);

  // Prescaler: one tick per DIV clocks (every clock when DIV == 1).
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // PWM counter wraps naturally from all-ones to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_reg <= '0;
    end else if (we && (addr == 4'd0)) begin
      enable_reg <= wdata[NUM_CH-1:0];
    end
  end

  // A boundary beats a coincident STATUS read so the flag stays set.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_reg <= 1'b0;
    end else if (wrap_tick) begin
      wrap_reg <= 1'b1;
    end else if (status_rd) begin
      wrap_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      always_ff @(posedge clk) begin
        if (reset) begin
          shadow_reg[gi] <= '0;
        end else if (we && (addr == 4'(gi + 2))) begin
          shadow_reg[gi] <= wdata[PWM_BITS-1:0];
        end
      end

      // The active duty only changes at a period boundary, so a DUTY write
      // never truncates or stretches the period in progress.
      always_ff @(posedge clk) begin
        if (reset) begin
          active_reg[gi] <= '0;
        end else if (wrap_tick) begin
`ifdef LED_PWM_FADE_EN
          if (active_reg[gi] < shadow_reg[gi]) begin
            active_reg[gi] <= active_reg[gi] + 1'b1;
          end else if (active_reg[gi] > shadow_reg[gi]) begin
            active_reg[gi] <= active_reg[gi] - 1'b1;
          end
`else
          active_reg[gi] <= shadow_reg[gi];
`endif
        end
      end

      // ENABLE gates the level directly so it acts on the next counter value.
      assign level[gi] = enable_reg[gi] && (cnt_reg < active_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_reg <= {NUM_CH{POL}};
    end else begin
      pwm_reg <= level ^ {NUM_CH{POL}};
    end
  end

  // Read mux sees pre-write register values, so a same-cycle write+read of
  // one address returns the old contents.
  always_comb begin
    read_mux = '0;
    if (addr == 4'd0) begin
      read_mux[NUM_CH-1:0] = enable_reg;
    end else if (addr == 4'd1) begin
      read_mux[PWM_BITS-1:0] = cnt_reg;
      read_mux[16]           = wrap_reg | wrap_tick;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr == 4'(i + 2)) begin
          read_mux[PWM_BITS-1:0] = shadow_reg[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= re;
      if (re) begin
        rdata_reg <= read_mux;
      end
    end
  end

  assign rdata   = rdata_reg;
  assign rvalid  = rvalid_reg;
  assign pwm_out = pwm_reg;

endmodule

// File: tb/tb_mmio_led_pwm.sv
module tb_mmio_led_pwm;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        re;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic [3:0]  pwm_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  mmio_led_pwm #(
    .NUM_CH(4), .PWM_BITS(4), .DIV(1), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .pwm_out(pwm_out)
  );

  // Independent time base: counter value during a cycle is cyc % 16.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every rvalid pops one expected read result.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", {31'b0, rvalid}, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("rdata", rdata, e);
        $display("read  data=%h expected=%h", rdata, e);
      end
    end
  end

  function automatic logic [31:0] st(input logic w);
    return {15'b0, w, 12'b0, 4'(cyc % 16)};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    $display("write addr=%0d data=%h", a, d);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    re = 1'b1; addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    re = 1'b0;
    chk("rvalid", {31'b0, rvalid}, 32'd1);
  endtask

  task automatic wrrd(input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
    we = 1'b1; re = 1'b1; addr = a; wdata = d;
    exp_q.push_back(e);
    $display("write+read addr=%0d data=%h", a, d);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    chk("rvalid_wr", {31'b0, rvalid}, 32'd1);
  endtask

  task automatic sync(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((cyc % 16) != p) && (n < 40));
    if ((cyc % 16) != p) begin
      total++; bad++;
      $error("FAIL sync_timeout: observed phase %0d expected %0d", cyc % 16, p);
    end
  endtask

  // Capture one full PWM period; sample i reflects counter value i.
  task automatic measure(output logic [3:0][15:0] v);
    sync(1);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      for (int c = 0; c < 4; c++) v[c][i] = pwm_out[c];
    end
    $display("period ch0=%h ch1=%h ch2=%h ch3=%h", v[0], v[1], v[2], v[3]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pwm", {28'b0, pwm_out}, 32'hF);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_queue", exp_q.size(), 32'd0);
    reset = 1'b0;
  endtask

`ifdef LED_PWM_FADE_EN
  localparam logic [15:0] FADE_EXP [4] = '{16'hFFFE, 16'hFFFC, 16'hFFF8, 16'hFFF8};
`else
  localparam logic [15:0] FADE_EXP [4] = '{16'hFFF8, 16'hFFF8, 16'hFFF8, 16'hFFF8};
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][15:0] v;

    // Reset with strobes asserted: they must be ignored.
    reset = 1'b1; we = 1'b1; re = 1'b1; addr = 4'd0; wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("rst_rvalid0", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata0", rdata, 32'd0);
    chk("rst_pwm0", {28'b0, pwm_out}, 32'hF);
    reset = 1'b0; we = 1'b0; re = 1'b0;

    repeat (40) begin
      @(negedge clk);
      chk("idle_pwm", {28'b0, pwm_out}, 32'hF);
    end
    rd(4'd0, 32'h0);

    // Basic duty, upper wdata bits discarded.
    sync(2);
    wr(4'd0, 32'hABCD_0001);
    wr(4'd2, 32'hFFFF_FF04);
    rd(4'd0, 32'h1);
    rd(4'd2, 32'h4);
    measure(v);
    chk("duty4_p1", {16'b0, v[0]}, 32'hFFF0);
    measure(v);
    chk("duty4_p2", {16'b0, v[0]}, 32'hFFF0);

    // Mid-period DUTY write affects only the next period.
    sync(0);
    fork
      measure(v);
      begin repeat (5) @(negedge clk); wr(4'd2, 32'd12); end
    join
    chk("duty_mid_cur", {16'b0, v[0]}, 32'hFFF0);
    measure(v);
    chk("duty_mid_next", {16'b0, v[0]}, 32'hF000);

    // Duty extremes.
    wr(4'd3, 32'd0);
    wr(4'd4, 32'd15);
    wr(4'd0, 32'h7);
    measure(v);
    chk("ext_ch0", {16'b0, v[0]}, 32'hF000);
    chk("ext_ch1_zero", {16'b0, v[1]}, 32'hFFFF);
    chk("ext_ch2_full", {16'b0, v[2]}, 32'h8000);
    chk("ext_ch3_off", {16'b0, v[3]}, 32'hFFFF);

    // ENABLE cleared during counter 6: outputs go inactive from counter 7.
    sync(0);
    fork
      measure(v);
      begin repeat (6) @(negedge clk); wr(4'd0, 32'h0); end
    join
    chk("dis_ch0", {16'b0, v[0]}, 32'hFF80);
    chk("dis_ch1", {16'b0, v[1]}, 32'hFFFF);
    chk("dis_ch2", {16'b0, v[2]}, 32'hFF80);

    // STATUS wrap flag, including a read on the boundary cycle.
    sync(5);
    rd(4'd1, st(1'b1));
    rd(4'd1, st(1'b0));
    sync(15);
    rd(4'd1, st(1'b1));
    rd(4'd1, st(1'b1));
    rd(4'd1, st(1'b0));
    wr(4'd1, 32'hFFFF_FFFF);
    wr(4'd15, 32'hFFFF_FFFF);
    rd(4'd0, 32'h0);
    rd(4'd2, 32'd12);
    rd(4'd3, 32'd0);
    rd(4'd4, 32'd15);
    rd(4'd5, 32'd0);
    rd(4'd15, 32'd0);
    rd(4'd6, 32'd0);
    rd(4'd1, st(1'b0));

    // Same-address write and read returns the old value.
    wrrd(4'd2, 32'd7, 32'd12);
    rd(4'd2, 32'd7);

    // Duty 0 -> 3 (fade or direct load).
    do_reset();
    rd(4'd1, st(1'b0));
    wr(4'd0, 32'h1);
    wr(4'd2, 32'd3);
    for (int p = 0; p < 4; p++) begin
      measure(v);
      chk("fade_period", {16'b0, v[0]}, {16'b0, FADE_EXP[p]});
    end

    // Reset mid-period returns everything to zero.
    wr(4'd2, 32'd15);
    rd(4'd2, 32'd15);
    sync(6);
    do_reset();
    rd(4'd0, 32'h0);
    rd(4'd2, 32'h0);
    rd(4'd1, st(1'b0));
    measure(v);
    for (int c = 0; c < 4; c++) chk("post_rst_pwm", {16'b0, v[c]}, 32'hFFFF);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_led_pwm.md
MMIO_LED_PWM -- requirements
Module: mmio_led_pwm

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of PWM output channels (1..8).
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter and duty width (2..16).
REQ-003 SHALL have parameter DIV, default 1, clock cycles per PWM counter step (1..65535).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1, which inverts every pwm_out bit when set (board LED/RGB pins are active-low).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port we, input, 1 bit: write strobe, one write per asserted cycle.
REQ-008 SHALL have port re, input, 1 bit: read strobe.
REQ-009 SHALL have port addr, input, 4 bits: word register address.
REQ-010 SHALL have port wdata, input, 32 bits: write data.
REQ-011 SHALL have port rdata, output, 32 bits: registered read data.
REQ-012 SHALL have port rvalid, output, 1 bit: high for exactly one cycle, the cycle after re.
REQ-013 SHALL have port pwm_out, output, NUM_CH bits: registered per-channel PWM drive at pin polarity.

Function
REQ-014 Register map SHALL be: addr 0 = ENABLE[NUM_CH-1:0] (RW); addr 1 = STATUS (RO: bits PWM_BITS-1:0 = PWM counter, bit 16 = period-wrap flag, cleared on read); addr 2+ch = DUTY shadow[PWM_BITS-1:0] of channel ch (RW).
REQ-015 Writes to RO or unmapped addresses SHALL be ignored; reads of unmapped addresses SHALL return 0; unused upper bits SHALL read 0; wdata upper bits SHALL be discarded.
REQ-016 rdata SHALL be captured on the cycle re is high and presented with rvalid the next cycle; rdata SHALL hold its value otherwise.
REQ-017 When we and re target the same address in one cycle, rdata SHALL return the pre-write value.
REQ-018 A prescaler SHALL count 0..DIV-1 and emit a one-cycle tick on the cycle it wraps; with DIV=1, tick SHALL be high every cycle.
REQ-019 The PWM counter SHALL advance by 1 on each tick and wrap from 2^PWM_BITS-1 to 0; the wrap tick SHALL be the period boundary.
REQ-020 At each period boundary, every channel's active duty SHALL load from its shadow (glitch-free update); DUTY writes SHALL NOT affect the current period.
REQ-021 Internal level for channel ch SHALL be ENABLE[ch] AND (counter < active_duty[ch]); duty 0 SHALL give constant off; duty 2^PWM_BITS-1 SHALL give on for all but one step per period.
REQ-022 pwm_out SHALL be the internal level registered one cycle after the counter value, XORed with ACTIVE_LOW.
REQ-023 An ENABLE write SHALL take effect on the next counter value, without waiting for the period boundary.
REQ-024 The wrap flag SHALL set at each period boundary; if a boundary coincides with a STATUS read, the flag SHALL read 1 and remain set.

Reset
REQ-025 While reset is high at a clk edge, prescaler, PWM counter, ENABLE, shadow and active duties, wrap flag, rdata and rvalid SHALL clear to 0.
REQ-026 pwm_out SHALL reset to the inactive level ({NUM_CH{ACTIVE_LOW}}); reset asserted mid-period SHALL abort the period, and counting SHALL restart from 0 on the first cycle after reset deasserts.
REQ-027 we and re SHALL be ignored in any cycle where reset is high.

Configuration
REQ-028 With macro LED_PWM_FADE_EN defined, at each period boundary each active duty SHALL step by exactly 1 toward its shadow (unchanged if equal), giving linear fades.
REQ-029 Without LED_PWM_FADE_EN, active duty SHALL load the shadow value directly at the boundary, and no fade logic SHALL be synthesised.

Verification (NUM_CH=4, PWM_BITS=4, DIV=1, ACTIVE_LOW=1)
REQ-030 Reset, then run 40 cycles -> pwm_out stays 4'b1111; a read of addr 0 gives rvalid one cycle later with rdata=0.
REQ-031 Write ENABLE=4'b0001 and DUTY0=4, wait for the period boundary -> pwm_out[0] is low 4 and high 12 of every 16 cycles.
REQ-032 Write DUTY0=12 mid-period while duty is 4 -> the current period keeps a 4-cycle on time and the next period has a 12-cycle on time (without the macro).
REQ-033 DUTY1=0 and DUTY2=15 with both enabled -> pwm_out[1] is constant 1; pwm_out[2] is low 15 of 16 cycles; ENABLE cleared mid-period -> the outputs go high on the next counter step.
REQ-034 Read STATUS after a wrap -> bit16=1; read again with no wrap in between -> bit16=0; write to addr 1 and to addr 15 -> no register changes.
REQ-035 With LED_PWM_FADE_EN defined, DUTY0 changed from 0 to 3 -> on times of 1, 2, 3, 3 cycles in successive periods; assert reset mid-fade -> all state returns to zero.
